// File: rtl/param_lock.sv
// Combination lock: next/enter digit entry on an LED bar, retry limit, timed flashing lockout.
// Optional PARAM_LOCK_PROG_EN adds reprogramming of the active code from UNLOCK.
module param_lock #(
    parameter int unsigned                  N_DIGITS       = 4,
    parameter int unsigned                  DIGIT_W        = 3,
    parameter logic [N_DIGITS*DIGIT_W-1:0]  PASSWORD       = 12'h2D1,
    parameter logic [(2**DIGIT_W)-1:0]      SECRET         = 8'hA5,
    parameter int unsigned                  MAX_TRIES      = 3,
    parameter logic [23:0]                  LOCKOUT_CYCLES = 24'd12000000,
    parameter logic [23:0]                  FLASH_CYCLES   = 24'd3000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             next_btn,
    input  logic                             enter_btn,
    input  logic                             relock,
    output logic [(2**DIGIT_W)-1:0]          leds,
    output logic                             unlocked,
    output logic                             lockout,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic [$clog2(N_DIGITS+1)-1:0]    digit_idx
);

    localparam int unsigned LED_W = 2**DIGIT_W;
    localparam int unsigned CW    = N_DIGITS * DIGIT_W;
    localparam int unsigned FW    = $clog2(MAX_TRIES + 1);
    localparam int unsigned IW    = $clog2(N_DIGITS + 1);

    localparam logic [2:0] S_ENTRY   = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_UNLOCK  = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
`ifdef PARAM_LOCK_PROG_EN
    localparam logic [2:0] S_PROG    = 3'd4;
`endif

    logic [2:0]         state_q, state_d;
    logic [DIGIT_W-1:0] pos_q, pos_d;
    logic               mismatch_q, mismatch_d;
    logic [23:0]        timer_q, timer_d;
    logic [23:0]        flash_q, flash_d;
    logic               next_q, enter_q;
    logic               nx, en;
    logic [IW-1:0]      idx_d;
    logic [FW-1:0]      fail_d;
    logic [LED_W-1:0]   leds_d, lock_leds;
    logic               unlocked_d, lockout_d;
    logic [DIGIT_W-1:0] exp_digit;
    logic [CW-1:0]      code_c;
    logic [31:0]        fail_inc;

`ifdef PARAM_LOCK_PROG_EN
    logic [CW-1:0]      code_q, code_d;
    logic [CW-1:0]      prog_q, prog_d;
    logic [CW-1:0]      shifted;
    assign code_c = code_q;
`else
    assign code_c = PASSWORD;
`endif

    assign nx = next_btn & ~next_q;
    assign en = enter_btn & ~enter_q;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        idx_d      = digit_idx;
        fail_d     = fail_cnt;
        mismatch_d = mismatch_q;
        timer_d    = timer_q;
        flash_d    = flash_q;
        lock_leds  = leds;
        exp_digit  = '0;
        fail_inc   = 32'(fail_cnt) + 32'd1;
`ifdef PARAM_LOCK_PROG_EN
        code_d     = code_q;
        prog_d     = prog_q;
        shifted    = CW'({prog_q, pos_q});
`endif
        // First-entered digit sits in the MSBs of the code
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (digit_idx == IW'(i)) begin
                exp_digit = code_c[(int'(N_DIGITS) - 1 - i) * int'(DIGIT_W) +: DIGIT_W];
            end
        end

        case (state_q)
            S_ENTRY: begin
                if (en) begin
                    mismatch_d = mismatch_q | (pos_q != exp_digit);
                    pos_d      = '0;
                    if (digit_idx == IW'(N_DIGITS - 1)) begin
                        idx_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        idx_d = digit_idx + IW'(1);
                    end
                end else if (nx) begin
                    pos_d = pos_q + DIGIT_W'(1);
                end
            end
            S_CHECK: begin
                mismatch_d = 1'b0;
                pos_d      = '0;
                idx_d      = '0;
                if (!mismatch_q) begin
                    state_d = S_UNLOCK;
                    fail_d  = '0;
                end else if (fail_inc < 32'(MAX_TRIES)) begin
                    state_d = S_ENTRY;
                    fail_d  = fail_cnt + FW'(1);
                end else begin
                    state_d   = S_LOCKOUT;
                    fail_d    = FW'(MAX_TRIES);
                    timer_d   = '0;
                    flash_d   = '0;
                    lock_leds = '1;
                end
            end
            S_UNLOCK: begin
                if (relock) begin
                    state_d = S_ENTRY;
                    pos_d   = '0;
                    idx_d   = '0;
                end
`ifdef PARAM_LOCK_PROG_EN
                else if (en) begin
                    state_d = S_PROG;
                    pos_d   = '0;
                    idx_d   = '0;
                end
`endif
            end
            S_LOCKOUT: begin
                if (timer_q != '1) timer_d = timer_q + 24'd1;
                if (flash_q >= FLASH_CYCLES - 24'd1) begin
                    flash_d   = '0;
                    lock_leds = ~leds;
                end else begin
                    flash_d = flash_q + 24'd1;
                end
                // A zero lockout length never expires
                if (LOCKOUT_CYCLES != 24'd0 && timer_q == LOCKOUT_CYCLES - 24'd1) begin
                    state_d = S_ENTRY;
                    fail_d  = '0;
                    pos_d   = '0;
                    idx_d   = '0;
                end
            end
`ifdef PARAM_LOCK_PROG_EN
            S_PROG: begin
                if (relock) begin
                    state_d = S_ENTRY;
                    pos_d   = '0;
                    idx_d   = '0;
                end else if (en) begin
                    prog_d = shifted;
                    pos_d  = '0;
                    if (digit_idx == IW'(N_DIGITS - 1)) begin
                        code_d  = shifted;
                        idx_d   = '0;
                        state_d = S_ENTRY;
                    end else begin
                        idx_d = digit_idx + IW'(1);
                    end
                end else if (nx) begin
                    pos_d = pos_q + DIGIT_W'(1);
                end
            end
`endif
            default: begin
                state_d    = S_ENTRY;
                pos_d      = '0;
                idx_d      = '0;
                mismatch_d = 1'b0;
            end
        endcase

        unlocked_d = (state_d == S_UNLOCK);
        lockout_d  = (state_d == S_LOCKOUT);
`ifdef PARAM_LOCK_PROG_EN
        if (state_d == S_PROG) unlocked_d = 1'b1;
`endif
        case (state_d)
            S_ENTRY:   leds_d = LED_W'(1) << pos_d;
            S_UNLOCK:  leds_d = SECRET;
            S_LOCKOUT: leds_d = lock_leds;
`ifdef PARAM_LOCK_PROG_EN
            S_PROG:    leds_d = LED_W'(1) << pos_d;
`endif
            default:   leds_d = '0;
        endcase
    end

    // State and output registers; button history resets high so held buttons give no edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_ENTRY;
            pos_q      <= '0;
            mismatch_q <= 1'b0;
            timer_q    <= '0;
            flash_q    <= '0;
            next_q     <= 1'b1;
            enter_q    <= 1'b1;
            leds       <= LED_W'(1);
            unlocked   <= 1'b0;
            lockout    <= 1'b0;
            fail_cnt   <= '0;
            digit_idx  <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            mismatch_q <= mismatch_d;
            timer_q    <= timer_d;
            flash_q    <= flash_d;
            next_q     <= next_btn;
            enter_q    <= enter_btn;
            leds       <= leds_d;
            unlocked   <= unlocked_d;
            lockout    <= lockout_d;
            fail_cnt   <= fail_d;
            digit_idx  <= idx_d;
        end
    end

`ifdef PARAM_LOCK_PROG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q <= PASSWORD;
            prog_q <= '0;
        end else begin
            code_q <= code_d;
            prog_q <= prog_d;
        end
    end
`endif

endmodule

// File: tb/tb_param_lock.sv
// Self-checking bench for param_lock: directed scenarios plus randomized attempts
// checked against a digit-queue reference model.
`timescale 1ns/1ps
module tb_param_lock;

    localparam int unsigned ND = 3;
    localparam int unsigned MT = 3;
    localparam int unsigned LC = 40;
    localparam int unsigned FC = 4;
    localparam logic [8:0]  PW  = 9'o251;
    localparam logic [7:0]  SEC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       next_btn = 1'b0;
    logic       enter_btn = 1'b0;
    logic       relock = 1'b0;
    logic [7:0] leds;
    logic       unlocked;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic [1:0] digit_idx;

    param_lock #(
        .N_DIGITS(ND), .DIGIT_W(3), .PASSWORD(PW), .SECRET(SEC), .MAX_TRIES(MT),
        .LOCKOUT_CYCLES(24'(LC)), .FLASH_CYCLES(24'(FC))
    ) dut (
        .clk(clk), .rst_n(rst_n), .next_btn(next_btn), .enter_btn(enter_btn),
        .relock(relock), .leds(leds), .unlocked(unlocked), .lockout(lockout),
        .fail_cnt(fail_cnt), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    // Reference model: 0 entry, 1 unlocked, 2 lockout, 3 programming
    int m_state;
    int m_pos;
    int m_fail;
    int m_code[3];
    int m_digits[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pos   = 0;
        m_fail  = 0;
        m_digits.delete();
        m_code  = '{2, 5, 1};
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_l;
        if (m_state == 1) exp_l = 32'(SEC);
        else              exp_l = 32'd1 << m_pos;
        chk({tag, ".leds"},      32'(leds),      exp_l);
        chk({tag, ".unlocked"},  32'(unlocked),  32'(m_state == 1 || m_state == 3));
        chk({tag, ".lockout"},   32'(lockout),   32'd0);
        chk({tag, ".fail_cnt"},  32'(fail_cnt),  32'(m_fail));
        chk({tag, ".digit_idx"}, 32'(digit_idx), 32'(m_digits.size()));
    endtask

    // 40 lockout cycles: flashing FF/00 every 4 cycles, random buttons must be ignored
    task automatic run_lockout(input string tag);
        for (int k = 0; k < int'(LC); k++) begin
            chk({tag, ".lo_flag"}, 32'(lockout),  32'd1);
            chk({tag, ".lo_unl"},  32'(unlocked), 32'd0);
            chk({tag, ".lo_fail"}, 32'(fail_cnt), 32'(MT));
            chk({tag, ".lo_leds"}, 32'(leds), ((k / int'(FC)) % 2 == 0) ? 32'hFF : 32'h00);
            if (k < int'(LC) - 1) begin
                next_btn  = 1'($urandom_range(0, 1));
                enter_btn = 1'($urandom_range(0, 1));
                relock    = 1'($urandom_range(0, 1));
            end else begin
                next_btn  = 1'b0;
                enter_btn = 1'b0;
                relock    = 1'b0;
            end
            tick();
        end
        m_state = 0;
        m_fail  = 0;
        m_pos   = 0;
        check_all({tag, ".lo_exit"});
    endtask

    task automatic press_next(input string tag);
        next_btn = 1'b1;
        tick();
        if (m_state == 0 || m_state == 3) m_pos = (m_pos + 1) % 8;
        check_all(tag);
        next_btn = 1'b0;
        tick();
        check_all(tag);
    endtask

    task automatic press_enter(input string tag, input bit both);
        bit match;
        enter_btn = 1'b1;
        next_btn  = both;
        tick();
        if (m_state == 0) begin
            m_digits.push_back(m_pos);
            m_pos = 0;
            if (m_digits.size() == int'(ND)) begin
                chk({tag, ".chk_leds"}, 32'(leds),      32'd0);
                chk({tag, ".chk_unl"},  32'(unlocked),  32'd0);
                chk({tag, ".chk_idx"},  32'(digit_idx), 32'd0);
                chk({tag, ".chk_fail"}, 32'(fail_cnt),  32'(m_fail));
                enter_btn = 1'b0;
                next_btn  = 1'b0;
                tick();
                match = 1'b1;
                for (int i = 0; i < int'(ND); i++) if (m_digits[i] != m_code[i]) match = 1'b0;
                m_digits.delete();
                if (match) begin
                    m_state = 1;
                    m_fail  = 0;
                end else begin
                    m_fail++;
                    m_state = (m_fail == int'(MT)) ? 2 : 0;
                end
                if (m_state == 2) run_lockout(tag);
                else              check_all(tag);
                return;
            end
        end else if (m_state == 1) begin
`ifdef PARAM_LOCK_PROG_EN
            m_state = 3;
            m_pos   = 0;
            m_digits.delete();
`endif
        end else if (m_state == 3) begin
            m_digits.push_back(m_pos);
            m_pos = 0;
            if (m_digits.size() == int'(ND)) begin
                for (int i = 0; i < int'(ND); i++) m_code[i] = m_digits[i];
                m_digits.delete();
                m_state = 0;
            end
        end
        check_all(tag);
        enter_btn = 1'b0;
        next_btn  = 1'b0;
        tick();
        check_all(tag);
    endtask

    task automatic press_relock(input string tag);
        relock = 1'b1;
        tick();
        if (m_state == 1 || m_state == 3) begin
            m_state = 0;
            m_pos   = 0;
            m_digits.delete();
        end
        check_all(tag);
        relock = 1'b0;
        tick();
        check_all(tag);
    endtask

    task automatic enter_code(input string tag, input int a, input int b, input int c, input bit wrap);
        int digs[3];
        int n;
        digs = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            n = ((digs[i] - m_pos) % 8 + 8) % 8 + (wrap ? 8 : 0);
            repeat (n) press_next(tag);
            press_enter(tag, 1'b0);
        end
    endtask

    initial begin
        int d0, d1, d2;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        check_all("reset");
        tick();
        check_all("reset_idle");

        // Correct code, buttons ignored while unlocked, then relock
        enter_code("correct", 2, 5, 1, 1'b0);
        chk("correct.unlocked", 32'(unlocked), 32'd1);
        press_next("unl_next");
`ifndef PARAM_LOCK_PROG_EN
        press_enter("unl_enter", 1'b0);
`endif
        press_relock("relock");
        chk("relock.leds", 32'(leds), 32'h01);

        // Wrap after 9 presses, then simultaneous next+enter at pos 3
        repeat (9) press_next("wrap");
        chk("wrap.leds", 32'(leds), 32'h02);
        repeat (2) press_next("to3");
        press_enter("both", 1'b1);
        chk("both.digit_idx", 32'(digit_idx), 32'd1);
        enter_code("both_rest", 5, 1, 0, 1'b0);
        chk("both.fail", 32'(fail_cnt), 32'd1);

        // Early wrong digit, then third failure into lockout
        enter_code("early_wrong", 0, 5, 1, 1'b0);
        chk("early_wrong.fail", 32'(fail_cnt), 32'd2);
        enter_code("third_wrong", 7, 7, 7, 1'b0);
        chk("post_lockout.fail", 32'(fail_cnt), 32'd0);

        // Reset mid-entry with enter held through reset
        enter_code("pre_rst_wrong", 1, 1, 1, 1'b0);
        press_next("mid");
        press_next("mid");
        press_enter("mid", 1'b0);
        repeat (5) press_next("mid");
        press_enter("mid", 1'b0);
        enter_btn = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check_all("mid_rst");
        tick();
        check_all("mid_rst_held");
        enter_btn = 1'b0;
        tick();
        check_all("mid_rst_rel");
        enter_code("post_rst", 2, 5, 1, 1'b0);
        chk("post_rst.unlocked", 32'(unlocked), 32'd1);
        press_relock("post_rst_relock");

        // Randomized attempts against the model
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                d0 = m_code[0]; d1 = m_code[1]; d2 = m_code[2];
            end else begin
                d0 = int'($urandom_range(0, 7));
                d1 = int'($urandom_range(0, 7));
                d2 = int'($urandom_range(0, 7));
            end
            enter_code("rand", d0, d1, d2, 1'($urandom_range(0, 1)));
            if (m_state == 1) press_relock("rand_relock");
        end

`ifdef PARAM_LOCK_PROG_EN
        // Reprogram to 703, abort a partial program, then reset restores 251
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        enter_code("prog_unlock", 2, 5, 1, 1'b0);
        press_enter("prog_enter", 1'b0);
        chk("prog.unlocked", 32'(unlocked), 32'd1);
        enter_code("prog_code", 7, 0, 3, 1'b0);
        chk("prog_done.unlocked", 32'(unlocked), 32'd0);
        enter_code("old_code", 2, 5, 1, 1'b0);
        chk("old_code.fail", 32'(fail_cnt), 32'd1);
        enter_code("new_code", 7, 0, 3, 1'b0);
        chk("new_code.unlocked", 32'(unlocked), 32'd1);
        press_enter("abort_enter", 1'b0);
        press_next("abort_next");
        press_enter("abort_digit", 1'b0);
        press_relock("abort_relock");
        enter_code("kept_code", 7, 0, 3, 1'b0);
        chk("kept_code.unlocked", 32'(unlocked), 32'd1);
        press_relock("kept_relock");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        enter_code("restored", 2, 5, 1, 1'b0);
        chk("restored.unlocked", 32'(unlocked), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
